// File: rtl/e203_exu_lpwb_arb_pkg.sv
// Shared sizes, source indices and output-buffer state encoding for the long-pipe write-back arbiter.
package e203_exu_lpwb_arb_pkg;

  localparam int unsigned LPWB_N_SRC   = 3;
  localparam int unsigned LPWB_ITAG_W  = 2;
  localparam int unsigned LPWB_XLEN    = 32;
  localparam int unsigned LPWB_RFIDX_W = 5;
  localparam int unsigned LPWB_STALL_W = 8;

  localparam int unsigned LPWB_SRC_LSU    = 0;
  localparam int unsigned LPWB_SRC_MULDIV = 1;
  localparam int unsigned LPWB_SRC_NICE   = 2;

  typedef enum logic [1:0] {
    LPWB_EMPTY    = 2'd0,
    LPWB_FULL_WB  = 2'd1,
    LPWB_FULL_EXC = 2'd2
  } lpwb_state_e;

endpackage

// File: rtl/e203_exu_lpwb_obuf.sv
// One-entry output buffer feeding the regfile write-back port or the exception port.
module e203_exu_lpwb_obuf
  import e203_exu_lpwb_arb_pkg::*;
#(
  parameter int unsigned XLEN    = LPWB_XLEN,
  parameter int unsigned RFIDX_W = LPWB_RFIDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               load_err,
  input  logic [XLEN-1:0]    load_wdat,
  input  logic [RFIDX_W-1:0] load_rdidx,
  input  logic [XLEN-1:0]    load_pc,
  output logic               can_load_c,
  output logic               wbck_o_valid,
  input  logic               wbck_o_ready,
  output logic [XLEN-1:0]    wbck_o_wdat,
  output logic [RFIDX_W-1:0] wbck_o_rdidx,
  output logic               excp_o_valid,
  input  logic               excp_o_ready,
  output logic [XLEN-1:0]    excp_o_pc
);

  lpwb_state_e state;
  logic        drain_c;

  // Entry leaves this cycle when its consumer accepts; a refill may land in the same cycle.
  always_comb begin
    drain_c    = ((state == LPWB_FULL_WB)  & wbck_o_ready) |
                 ((state == LPWB_FULL_EXC) & excp_o_ready);
    can_load_c = (state == LPWB_EMPTY) | drain_c;
  end

  // Buffer state, registered valids and held payload; load is only raised when can_load_c is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LPWB_EMPTY;
      wbck_o_valid <= 1'b0;
      excp_o_valid <= 1'b0;
      wbck_o_wdat  <= '0;
      wbck_o_rdidx <= '0;
      excp_o_pc    <= '0;
    end else if (load) begin
      if (load_err) begin
        state        <= LPWB_FULL_EXC;
        wbck_o_valid <= 1'b0;
        excp_o_valid <= 1'b1;
        excp_o_pc    <= load_pc;
      end else begin
        state        <= LPWB_FULL_WB;
        wbck_o_valid <= 1'b1;
        excp_o_valid <= 1'b0;
        wbck_o_wdat  <= load_wdat;
        wbck_o_rdidx <= load_rdidx;
      end
    end else if (drain_c) begin
      state        <= LPWB_EMPTY;
      wbck_o_valid <= 1'b0;
      excp_o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/e203_exu_lpwb_arb.sv
// In-order long-pipe completion arbiter: only the completion tagged with the OITF head may retire.
module e203_exu_lpwb_arb
  import e203_exu_lpwb_arb_pkg::*;
#(
  parameter int unsigned N_SRC   = LPWB_N_SRC,
  parameter int unsigned ITAG_W  = LPWB_ITAG_W,
  parameter int unsigned XLEN    = LPWB_XLEN,
  parameter int unsigned RFIDX_W = LPWB_RFIDX_W,
  parameter int unsigned STALL_W = LPWB_STALL_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SRC-1:0]           src_i_valid,
  output logic [N_SRC-1:0]           src_i_ready,
  input  logic [N_SRC*ITAG_W-1:0]    src_i_itag,
  input  logic [N_SRC-1:0]           src_i_rdwen,
  input  logic [N_SRC*RFIDX_W-1:0]   src_i_rdidx,
  input  logic [N_SRC*XLEN-1:0]      src_i_wdat,
  input  logic [N_SRC-1:0]           src_i_err,
  input  logic [N_SRC*XLEN-1:0]      src_i_pc,
  input  logic                       oitf_empty,
  input  logic [ITAG_W-1:0]          oitf_ret_ptr,
  output logic                       oitf_ret_ena,
  output logic                       wbck_o_valid,
  input  logic                       wbck_o_ready,
  output logic [XLEN-1:0]            wbck_o_wdat,
  output logic [RFIDX_W-1:0]         wbck_o_rdidx,
  output logic                       excp_o_valid,
  input  logic                       excp_o_ready,
  output logic [XLEN-1:0]            excp_o_pc,
  output logic                       stall_sat
);

  localparam logic [STALL_W-1:0] CNT_MAX = '1;

  logic [N_SRC-1:0]   cand;
  logic [N_SRC-1:0]   win_oh;
  logic               win_any;
  logic               win_rdwen;
  logic               win_err;
  logic [RFIDX_W-1:0] win_rdidx;
  logic [XLEN-1:0]    win_wdat;
  logic [XLEN-1:0]    win_pc;
  logic               win_bypass;
  logic               win_ready;
  logic               buf_load;
  logic               can_load_c;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_cnt_nxt;

  // Tag match against the OITF head; nothing matches while the OITF is empty.
  always_comb begin
    cand = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      cand[i] = src_i_valid[i] & (src_i_itag[i*ITAG_W +: ITAG_W] == oitf_ret_ptr) & ~oitf_empty;
    end
  end

  // Fixed priority, lowest index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    win_oh    = '0;
    win_any   = 1'b0;
    win_rdwen = 1'b0;
    win_err   = 1'b0;
    win_rdidx = '0;
    win_wdat  = '0;
    win_pc    = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_oh    = N_SRC'(1) << i;
        win_any   = 1'b1;
        win_rdwen = src_i_rdwen[i];
        win_err   = src_i_err[i];
        win_rdidx = src_i_rdidx[i*RFIDX_W +: RFIDX_W];
        win_wdat  = src_i_wdat[i*XLEN +: XLEN];
        win_pc    = src_i_pc[i*XLEN +: XLEN];
      end
    end
  end

  // Completions with nothing to write and no exception retire directly, ignoring buffer occupancy.
  always_comb begin
    win_bypass   = ~win_rdwen & ~win_err;
    win_ready    = win_bypass | can_load_c;
    src_i_ready  = win_oh & {N_SRC{win_ready}};
    oitf_ret_ena = win_any & win_ready;
    buf_load     = oitf_ret_ena & ~win_bypass;
  end

  e203_exu_lpwb_obuf #(
    .XLEN    (XLEN),
    .RFIDX_W (RFIDX_W)
  ) u_obuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (buf_load),
    .load_err     (win_err),
    .load_wdat    (win_wdat),
    .load_rdidx   (win_rdidx),
    .load_pc      (win_pc),
    .can_load_c   (can_load_c),
    .wbck_o_valid (wbck_o_valid),
    .wbck_o_ready (wbck_o_ready),
    .wbck_o_wdat  (wbck_o_wdat),
    .wbck_o_rdidx (wbck_o_rdidx),
    .excp_o_valid (excp_o_valid),
    .excp_o_ready (excp_o_ready),
    .excp_o_pc    (excp_o_pc)
  );

  // Head-of-line watchdog: counts cycles with work outstanding but no matching completion.
  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (oitf_empty | oitf_ret_ena) begin
      stall_cnt_nxt = '0;
    end else if (~|cand && (stall_cnt != CNT_MAX)) begin
      stall_cnt_nxt = stall_cnt + STALL_W'(1);
    end
  end

  // Counter and its saturation flag, registered together so the flag tracks the count exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      stall_sat <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      stall_sat <= (stall_cnt_nxt == CNT_MAX);
    end
  end

endmodule

// File: tb/tb_e203_exu_lpwb_arb.sv
// Directed bench for the long-pipe write-back arbiter; inputs change on the falling edge.
module tb_e203_exu_lpwb_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  src_i_valid;
  logic [2:0]  src_i_ready;
  logic [5:0]  src_i_itag;
  logic [2:0]  src_i_rdwen;
  logic [14:0] src_i_rdidx;
  logic [95:0] src_i_wdat;
  logic [2:0]  src_i_err;
  logic [95:0] src_i_pc;
  logic        oitf_empty;
  logic [1:0]  oitf_ret_ptr;
  logic        oitf_ret_ena;
  logic        wbck_o_valid;
  logic        wbck_o_ready;
  logic [31:0] wbck_o_wdat;
  logic [4:0]  wbck_o_rdidx;
  logic        excp_o_valid;
  logic        excp_o_ready;
  logic [31:0] excp_o_pc;
  logic        stall_sat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  e203_exu_lpwb_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_i_valid  (src_i_valid),
    .src_i_ready  (src_i_ready),
    .src_i_itag   (src_i_itag),
    .src_i_rdwen  (src_i_rdwen),
    .src_i_rdidx  (src_i_rdidx),
    .src_i_wdat   (src_i_wdat),
    .src_i_err    (src_i_err),
    .src_i_pc     (src_i_pc),
    .oitf_empty   (oitf_empty),
    .oitf_ret_ptr (oitf_ret_ptr),
    .oitf_ret_ena (oitf_ret_ena),
    .wbck_o_valid (wbck_o_valid),
    .wbck_o_ready (wbck_o_ready),
    .wbck_o_wdat  (wbck_o_wdat),
    .wbck_o_rdidx (wbck_o_rdidx),
    .excp_o_valid (excp_o_valid),
    .excp_o_ready (excp_o_ready),
    .excp_o_pc    (excp_o_pc),
    .stall_sat    (stall_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [1:0] tag, input logic rdwen,
                         input logic err, input logic [4:0] rd, input logic [31:0] wdat,
                         input logic [31:0] pc);
    src_i_valid[i]          = v;
    src_i_itag[i*2 +: 2]    = tag;
    src_i_rdwen[i]          = rdwen;
    src_i_err[i]            = err;
    src_i_rdidx[i*5 +: 5]   = rd;
    src_i_wdat[i*32 +: 32]  = wdat;
    src_i_pc[i*32 +: 32]    = pc;
  endtask

  task automatic clr_src();
    src_i_valid = '0; src_i_itag = '0; src_i_rdwen = '0; src_i_err = '0;
    src_i_rdidx = '0; src_i_wdat = '0; src_i_pc = '0;
  endtask

  // One clock: returns on the falling edge, ready for new inputs.
  task automatic next();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Protocol guard: the bench must never present two sources matching the OITF head.
  always @(posedge clk) begin
    if (rst_n && !oitf_empty) begin
      int n;
      n = 0;
      for (int i = 0; i < 3; i++)
        if (src_i_valid[i] && src_i_itag[i*2 +: 2] == oitf_ret_ptr) n++;
      assert (n <= 1) else begin
        errors++;
        $error("FAIL multi_cand: observed=%0d expected<=1", n);
      end
    end
  end

  initial begin
    rst_n = 1'b0; clr_src();
    oitf_empty = 1'b1; oitf_ret_ptr = 2'd0;
    wbck_o_ready = 1'b1; excp_o_ready = 1'b1;
    next(); next();
    #1;
    chk("rst_wbck_valid", 32'(wbck_o_valid), 32'd0);
    chk("rst_excp_valid", 32'(excp_o_valid), 32'd0);
    chk("rst_ret_ena",    32'(oitf_ret_ena), 32'd0);
    chk("rst_stall_sat",  32'(stall_sat),    32'd0);
    chk("rst_wdat",       wbck_o_wdat,       32'd0);
    chk("rst_rdidx",      32'(wbck_o_rdidx), 32'd0);
    chk("rst_pc",         excp_o_pc,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next();

    // stale tag while OITF empty is refused
    set_src(0, 1'b1, 2'd0, 1'b1, 1'b0, 5'd1, 32'h1, 32'h0);
    #1;
    chk("empty_ready",   32'(src_i_ready),  32'd0);
    chk("empty_ret_ena", 32'(oitf_ret_ena), 32'd0);
    clr_src();
    next();

    // 1: LSU write-back
    oitf_empty = 1'b0; oitf_ret_ptr = 2'd1;
    set_src(0, 1'b1, 2'd1, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0);
    #1;
    chk("t1_ready",   32'(src_i_ready),  32'b001);
    chk("t1_ret_ena", 32'(oitf_ret_ena), 32'd1);
    chk("t1_no_early_valid", 32'(wbck_o_valid), 32'd0);
    next();
    clr_src(); oitf_ret_ptr = 2'd2;
    #1;
    chk("t1_ret_ena_off", 32'(oitf_ret_ena), 32'd0);
    chk("t1_wb_valid", 32'(wbck_o_valid), 32'd1);
    chk("t1_wb_rdidx", 32'(wbck_o_rdidx), 32'd5);
    chk("t1_wb_wdat",  wbck_o_wdat,       32'hDEAD_BEEF);
    next();
    #1;
    chk("t1_wb_drained", 32'(wbck_o_valid), 32'd0);

    // 2: MULDIV waits for its tag
    oitf_ret_ptr = 2'd1;
    set_src(1, 1'b1, 2'd2, 1'b1, 1'b0, 5'd7, 32'h1234_5678, 32'h0);
    #1;
    chk("t2_wait_ready0", 32'(src_i_ready),  32'd0);
    chk("t2_wait_ret0",   32'(oitf_ret_ena), 32'd0);
    next();
    #1;
    chk("t2_wait_ready1", 32'(src_i_ready),  32'd0);
    next();
    oitf_ret_ptr = 2'd2;
    #1;
    chk("t2_ready",   32'(src_i_ready),  32'b010);
    chk("t2_ret_ena", 32'(oitf_ret_ena), 32'd1);
    next();
    clr_src(); oitf_ret_ptr = 2'd3;
    #1;
    chk("t2_ret_once", 32'(oitf_ret_ena), 32'd0);
    chk("t2_wb_valid", 32'(wbck_o_valid), 32'd1);
    chk("t2_wb_wdat",  wbck_o_wdat,       32'h1234_5678);
    chk("t2_wb_rdidx", 32'(wbck_o_rdidx), 32'd7);
    next();

    // 3: back-pressure holds data and blocks the next candidate; release refills same cycle
    wbck_o_ready = 1'b0;
    set_src(0, 1'b1, 2'd3, 1'b1, 1'b0, 5'd9, 32'hAAAA_0001, 32'h0);
    #1;
    chk("t3_load_ready", 32'(src_i_ready), 32'b001);
    next();
    clr_src(); oitf_ret_ptr = 2'd0;
    set_src(2, 1'b1, 2'd0, 1'b1, 1'b0, 5'd10, 32'hBBBB_0002, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_hold_valid", 32'(wbck_o_valid), 32'd1);
      chk("t3_hold_wdat",  wbck_o_wdat,       32'hAAAA_0001);
      chk("t3_hold_rdidx", 32'(wbck_o_rdidx), 32'd9);
      chk("t3_blk_ready",  32'(src_i_ready),  32'd0);
      chk("t3_blk_ret",    32'(oitf_ret_ena), 32'd0);
      next();
    end
    wbck_o_ready = 1'b1;
    #1;
    chk("t3_refill_ready", 32'(src_i_ready),  32'b100);
    chk("t3_refill_ret",   32'(oitf_ret_ena), 32'd1);
    next();
    clr_src(); oitf_ret_ptr = 2'd1;
    #1;
    chk("t3_new_valid", 32'(wbck_o_valid), 32'd1);
    chk("t3_new_wdat",  wbck_o_wdat,       32'hBBBB_0002);
    chk("t3_new_rdidx", 32'(wbck_o_rdidx), 32'd10);
    next();
    #1;
    chk("t3_drained", 32'(wbck_o_valid), 32'd0);

    // 4: exception wins over rdwen
    set_src(0, 1'b1, 2'd1, 1'b1, 1'b1, 5'd3, 32'h0000_FFFF, 32'h8000_0010);
    #1;
    chk("t4_ready", 32'(src_i_ready), 32'b001);
    next();
    clr_src(); oitf_ret_ptr = 2'd2;
    #1;
    chk("t4_excp_valid", 32'(excp_o_valid), 32'd1);
    chk("t4_excp_pc",    excp_o_pc,         32'h8000_0010);
    chk("t4_no_wb",      32'(wbck_o_valid), 32'd0);
    next();
    #1;
    chk("t4_excp_drained", 32'(excp_o_valid), 32'd0);
    chk("t4_no_wb_after",  32'(wbck_o_valid), 32'd0);

    // 5: bypass retire while buffer is full
    wbck_o_ready = 1'b0;
    set_src(1, 1'b1, 2'd2, 1'b1, 1'b0, 5'd12, 32'hCAFE_0005, 32'h0);
    #1;
    chk("t5_load_ready", 32'(src_i_ready), 32'b010);
    next();
    oitf_ret_ptr = 2'd3;
    set_src(1, 1'b1, 2'd3, 1'b0, 1'b0, 5'd1, 32'h0000_5555, 32'h0);
    #1;
    chk("t5_byp_ready", 32'(src_i_ready),  32'b010);
    chk("t5_byp_ret",   32'(oitf_ret_ena), 32'd1);
    chk("t5_full_wdat", wbck_o_wdat,       32'hCAFE_0005);
    next();
    clr_src(); oitf_ret_ptr = 2'd0;
    #1;
    chk("t5_kept_valid", 32'(wbck_o_valid), 32'd1);
    chk("t5_kept_wdat",  wbck_o_wdat,       32'hCAFE_0005);
    chk("t5_kept_rdidx", 32'(wbck_o_rdidx), 32'd12);
    wbck_o_ready = 1'b1;
    next();
    #1;
    chk("t5_drained", 32'(wbck_o_valid), 32'd0);

    // 6: watchdog saturation and clear
    oitf_empty = 1'b1;
    next();
    oitf_empty = 1'b0;
    repeat (254) next();
    #1;
    chk("t6_not_yet_sat", 32'(stall_sat), 32'd0);
    next();
    #1;
    chk("t6_sat", 32'(stall_sat), 32'd1);
    repeat (3) next();
    #1;
    chk("t6_sat_held", 32'(stall_sat), 32'd1);
    set_src(0, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    chk("t6_ret", 32'(oitf_ret_ena), 32'd1);
    next();
    clr_src(); oitf_ret_ptr = 2'd1;
    #1;
    chk("t6_sat_cleared", 32'(stall_sat), 32'd0);

    // async reset mid-FULL discards the entry
    wbck_o_ready = 1'b0;
    set_src(0, 1'b1, 2'd1, 1'b1, 1'b0, 5'd4, 32'h0000_0077, 32'h0);
    next();
    clr_src(); oitf_ret_ptr = 2'd2;
    #1;
    chk("rst_mid_full_before", 32'(wbck_o_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wb_valid",   32'(wbck_o_valid), 32'd0);
    chk("rst_mid_excp_valid", 32'(excp_o_valid), 32'd0);
    chk("rst_mid_wdat",       wbck_o_wdat,       32'd0);
    next();
    rst_n = 1'b1;
    next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
